// File: rtl/madd_seq_ctrl.sv
// Command sequencer for the dual-lane saturating pair-adder: interleaves A/B operand
// reads with the adder enable, then writes each returned result to C+k.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for i_start
// ST_ISSUE | one read per cycle, alternating A[k] / B[k]
// ST_DRAIN | reads done, collecting the remaining adder results
// ST_FLUSH | aborted; 4 cycles for in-flight results to fall away
// ST_FIN   | final cycle of a command (o_done high), busy drops next
module madd_seq_ctrl #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 10,
   parameter int LWIDTH = 10
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              i_start,
   input  logic [AWIDTH-1:0] i_base_a,
   input  logic [AWIDTH-1:0] i_base_b,
   input  logic [AWIDTH-1:0] i_base_c,
   input  logic [LWIDTH-1:0] i_len,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_rd_en,
   output logic [AWIDTH-1:0] o_rd_addr,
   output logic              o_madd_en,
   input  logic              i_madd_valid,
   input  logic [DWIDTH-1:0] i_madd_out,
   output logic              o_wr_en,
   output logic [AWIDTH-1:0] o_wr_addr,
   output logic [DWIDTH-1:0] o_wr_data
);

   localparam int CWIDTH = LWIDTH + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FLUSH, ST_FIN} state_t;

   state_t              state;
   logic [AWIDTH-1:0]   base_a;
   logic [AWIDTH-1:0]   base_b;
   logic [AWIDTH-1:0]   base_c;
   logic [LWIDTH-1:0]   rd_idx;
   logic [LWIDTH-1:0]   wr_idx;
   logic                phase;
   logic [CWIDTH-1:0]   rd_left;
   logic [LWIDTH-1:0]   wr_left;
   logic [1:0]          flush_tmr;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state     <= ST_IDLE;
         base_a    <= '0;
         base_b    <= '0;
         base_c    <= '0;
         rd_idx    <= '0;
         wr_idx    <= '0;
         phase     <= 1'b0;
         rd_left   <= '0;
         wr_left   <= '0;
         flush_tmr <= '0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_rd_en   <= 1'b0;
         o_rd_addr <= '0;
         o_madd_en <= 1'b0;
         o_wr_en   <= 1'b0;
         o_wr_addr <= '0;
         o_wr_data <= '0;
      end else begin
         o_done  <= 1'b0;
         o_wr_en <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  base_a <= i_base_a;
                  base_b <= i_base_b;
                  base_c <= i_base_c;
                  rd_idx <= '0;
                  wr_idx <= '0;
                  o_busy <= 1'b1;
                  if (i_len == '0) begin
                     o_done <= 1'b1;
                     state  <= ST_FIN;
                  end else begin
                     // A[0] goes out on the accepting edge, so the remaining count excludes it
                     o_rd_en   <= 1'b1;
                     o_madd_en <= 1'b1;
                     o_rd_addr <= i_base_a;
                     phase     <= 1'b1;
                     rd_left   <= {i_len, 1'b0} - CWIDTH'(1);
                     wr_left   <= i_len;
                     state     <= ST_ISSUE;
                  end
               end
            end

            ST_ISSUE, ST_DRAIN: begin
               if (i_abort) begin
                  o_rd_en   <= 1'b0;
                  o_madd_en <= 1'b0;
                  flush_tmr <= 2'd3;
                  state     <= ST_FLUSH;
               end else begin
                  if (state == ST_ISSUE) begin
                     if (rd_left == '0) begin
                        o_rd_en   <= 1'b0;
                        o_madd_en <= 1'b0;
                        state     <= ST_DRAIN;
                     end else begin
                        rd_left <= rd_left - CWIDTH'(1);
                        phase   <= ~phase;
                        if (phase) begin
                           o_rd_addr <= base_b + AWIDTH'(rd_idx);
                           rd_idx    <= rd_idx + LWIDTH'(1);
                        end else begin
                           o_rd_addr <= base_a + AWIDTH'(rd_idx);
                        end
                     end
                  end
                  if (i_madd_valid) begin
                     o_wr_en   <= 1'b1;
                     o_wr_addr <= base_c + AWIDTH'(wr_idx);
                     o_wr_data <= i_madd_out;
                     wr_idx    <= wr_idx + LWIDTH'(1);
                     wr_left   <= wr_left - LWIDTH'(1);
                     if (wr_left == LWIDTH'(1)) begin
                        o_done <= 1'b1;
                        state  <= ST_FIN;
                     end
                  end
               end
            end

            ST_FLUSH: begin
               if (flush_tmr == '0) begin
                  o_busy <= 1'b0;
                  state  <= ST_IDLE;
               end else begin
                  flush_tmr <= flush_tmr - 2'd1;
               end
            end

            ST_FIN: begin
               o_busy <= 1'b0;
               state  <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_madd_seq_ctrl.sv
// Bench for madd_seq_ctrl: behavioural memory + pair-adder environment, expected
// reads/writes queued at command issue and checked by a negedge monitor.
module tb_madd_seq_ctrl;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        i_start;
   logic [9:0]  i_base_a, i_base_b, i_base_c;
   logic [9:0]  i_len;
   logic        i_abort;
   logic        o_busy, o_done, o_rd_en, o_madd_en, o_wr_en;
   logic [9:0]  o_rd_addr, o_wr_addr;
   logic [31:0] o_wr_data;
   logic        i_madd_valid;
   logic [31:0] i_madd_out;

   madd_seq_ctrl dut (
      .clk(clk), .arst_n(arst_n), .i_start(i_start),
      .i_base_a(i_base_a), .i_base_b(i_base_b), .i_base_c(i_base_c),
      .i_len(i_len), .i_abort(i_abort),
      .o_busy(o_busy), .o_done(o_done),
      .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_madd_en(o_madd_en),
      .i_madd_valid(i_madd_valid), .i_madd_out(i_madd_out),
      .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", nm, act, exp);
      end
   endtask

   // Lane-wise signed add clamped symmetrically to +/-32767.
   function automatic logic [15:0] sat16(input logic [15:0] x, input logic [15:0] y);
      int s;
      s = int'($signed(x)) + int'($signed(y));
      if (s > 32767) s = 32767;
      if (s < -32767) s = -32767;
      return s[15:0];
   endfunction

   function automatic logic [31:0] pair_sat(input logic [31:0] a, input logic [31:0] b);
      return {sat16(a[31:16], b[31:16]), sat16(a[15:0], b[15:0])};
   endfunction

   // Environment: memory with 2-cycle read latency feeding a pair-adder.
   logic [31:0] mem [1024];
   logic        rd_d1 = 1'b0, men_d1 = 1'b0, men_d2 = 1'b0, m_sel = 1'b0, m_valid = 1'b0;
   logic [9:0]  addr_d1 = '0;
   logic [31:0] data_d2 = '0, m_opa = '0, m_out = '0;

   always @(posedge clk) begin
      rd_d1   <= o_rd_en;
      addr_d1 <= o_rd_addr;
      men_d1  <= o_madd_en;
      men_d2  <= men_d1;
      data_d2 <= rd_d1 ? mem[addr_d1] : 32'hDEAD_BEEF;
      m_valid <= 1'b0;
      if (!men_d2) m_sel <= 1'b0;
      else if (!m_sel) begin
         m_opa <= data_d2;
         m_sel <= 1'b1;
      end else begin
         m_out   <= pair_sat(m_opa, data_d2);
         m_valid <= 1'b1;
         m_sel   <= 1'b0;
      end
   end

   assign i_madd_valid = m_valid;
   assign i_madd_out   = m_out;

   typedef struct {
      logic [9:0]  addr;
      logic [31:0] data;
      bit          last;
   } wr_t;

   logic [9:0] rd_q [$];
   wr_t        wr_q [$];
   int         zdone_pending = 0;
   int         run = 0;

   always @(negedge clk) begin
      logic [9:0] ea;
      wr_t        ew;
      chk(o_rd_en == o_madd_en, "rd_madd_en_equal", 32'(o_madd_en), 32'(o_rd_en));
      if (o_madd_en) run++;
      else begin
         if (run != 0) chk(run % 2 == 0, "en_run_even", 32'(run), 32'(run + 1));
         run = 0;
      end
      if (o_rd_en) begin
         if (rd_q.size() == 0) chk(1'b0, "rd_unexpected", 32'(o_rd_addr), 32'h0);
         else begin
            ea = rd_q.pop_front();
            chk(o_rd_addr == ea, "rd_addr", 32'(o_rd_addr), 32'(ea));
         end
      end
      if (o_wr_en) begin
         if (wr_q.size() == 0) chk(1'b0, "wr_unexpected", 32'(o_wr_addr), 32'h0);
         else begin
            ew = wr_q.pop_front();
            chk(o_wr_addr == ew.addr, "wr_addr", 32'(o_wr_addr), 32'(ew.addr));
            chk(o_wr_data == ew.data, "wr_data", o_wr_data, ew.data);
            chk(o_done == ew.last, "done_with_last_wr", 32'(o_done), 32'(ew.last));
         end
      end else if (o_done) begin
         chk(zdone_pending > 0, "done_unexpected", 32'(o_done), 32'h0);
         if (zdone_pending > 0) zdone_pending--;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Queues the reference reads/writes, then strobes start; returns in the first issue cycle.
   task automatic start_cmd(input logic [9:0] ba, input logic [9:0] bb, input logic [9:0] bc, input int n);
      wr_t        w;
      logic [9:0] a, b;
      for (int k = 0; k < n; k++) begin
         a = ba + 10'(k);
         b = bb + 10'(k);
         rd_q.push_back(a);
         rd_q.push_back(b);
         w.addr = bc + 10'(k);
         w.data = pair_sat(mem[a], mem[b]);
         w.last = (k == n - 1);
         wr_q.push_back(w);
      end
      if (n == 0) zdone_pending++;
      i_base_a = ba;
      i_base_b = bb;
      i_base_c = bc;
      i_len    = 10'(n);
      i_start  = 1'b1;
      step();
      i_start  = 1'b0;
   endtask

   task automatic wait_done(input int exp_t, input string nm);
      int t = 0;
      while (!o_done && t < 300) begin
         step();
         t++;
      end
      chk(o_done && t == exp_t, {nm, "_done_cycle"}, 32'(t), 32'(exp_t));
      chk(o_busy == 1'b1, {nm, "_busy_at_done"}, 32'(o_busy), 32'h1);
      step();
      chk(o_busy == 1'b0, {nm, "_busy_drop"}, 32'(o_busy), 32'h0);
      chk(rd_q.size() == 0 && wr_q.size() == 0 && zdone_pending == 0, {nm, "_sb_empty"},
          32'(rd_q.size() + wr_q.size() + zdone_pending), 32'h0);
   endtask

   function automatic bit outs_zero();
      return {o_busy, o_done, o_rd_en, o_madd_en, o_wr_en} == 5'b0 &&
             o_rd_addr == '0 && o_wr_addr == '0 && o_wr_data == '0;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      arst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
      i_base_a = '0; i_base_b = '0; i_base_c = '0; i_len = '0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom();
      repeat (3) @(posedge clk);
      #1;
      chk(outs_zero(), "reset_outputs", 32'({o_busy, o_done, o_rd_en, o_wr_en}), 32'h0);
      arst_n = 1'b1;
      step(); step();
      chk(o_busy == 1'b0, "idle_busy", 32'(o_busy), 32'h0);

      // Single pair
      mem[10'h010] = 32'h0001_0002;
      mem[10'h050] = 32'h0003_0004;
      start_cmd(10'h010, 10'h050, 10'h020, 1);
      wr_q[0].data = 32'h0004_0006;
      wait_done(5, "n1");

      // Zero length
      start_cmd(10'h111, 10'h222, 10'h333, 0);
      wait_done(0, "n0");

      // Address wrap on the A stream
      start_cmd(10'h3FE, 10'h100, 10'h3FD, 4);
      wait_done(11, "wrap");

      // Saturation passes straight through to memory
      mem[10'h200] = 32'h7000_9000;
      mem[10'h201] = 32'h7000_9000;
      start_cmd(10'h200, 10'h201, 10'h060, 1);
      wr_q[0].data = 32'h7FFF_8001;
      wait_done(5, "sat");

      // Abort mid-issue, then a fresh command
      start_cmd(10'h080, 10'h0C0, 10'h300, 4);
      step(); step(); step();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk(!o_rd_en && !o_madd_en, "abort_en_drop", 32'({o_rd_en, o_madd_en}), 32'h0);
      rd_q.delete();
      wr_q.delete();
      for (int i = 0; i < 4; i++) begin
         chk(o_busy == 1'b1, "flush_busy", 32'(o_busy), 32'h1);
         step();
      end
      chk(o_busy == 1'b0, "flush_end", 32'(o_busy), 32'h0);
      start_cmd(10'h010, 10'h050, 10'h021, 1);
      wait_done(5, "after_abort");

      // Start while busy is ignored
      start_cmd(10'h140, 10'h180, 10'h340, 3);
      step(); step();
      i_start = 1'b1; i_base_a = 10'h000; i_base_b = 10'h001; i_base_c = 10'h002; i_len = 10'd7;
      step();
      i_start = 1'b0;
      wait_done(6, "start_busy");

      // Abort coincident with the final adder result
      start_cmd(10'h1A0, 10'h1B0, 10'h1C0, 1);
      step(); step(); step(); step();
      wr_q.delete();
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk(o_wr_en == 1'b0 && o_done == 1'b0, "abort_wins", 32'({o_wr_en, o_done}), 32'h0);
      repeat (4) step();
      chk(o_busy == 1'b0, "abort_wins_idle", 32'(o_busy), 32'h0);

      // Abort in idle does nothing
      i_abort = 1'b1;
      step();
      i_abort = 1'b0;
      chk(o_busy == 1'b0, "abort_idle", 32'(o_busy), 32'h0);

      // Reset mid-issue; stray adder result afterwards must not write
      start_cmd(10'h220, 10'h240, 10'h260, 5);
      step(); step(); step();
      @(negedge clk);
      #1;
      arst_n = 1'b0;
      #1;
      chk(outs_zero(), "reset_mid_issue", 32'({o_busy, o_done, o_rd_en, o_wr_en}), 32'h0);
      rd_q.delete();
      wr_q.delete();
      step();
      arst_n = 1'b1;
      repeat (8) step();
      chk(o_busy == 1'b0, "post_reset_idle", 32'(o_busy), 32'h0);

      // Random commands
      for (int r = 0; r < 10; r++) begin
         int n;
         n = $urandom_range(1, 6);
         start_cmd(10'($urandom()), 10'($urandom()), 10'($urandom()), n);
         wait_done(2 * n + 3, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
